core_rx: RTL
============

Name: core_rx

Overview:
- Receive-side counterpart of the 16x4 serial word transmitter: deserialises a 64-bit frame from a single serial line back into 16 words of 4 bits.
- Bit order matches the transmitter: word 0 first, LSB (bit 0) first within each word.
- Received words go into an internal 16x4 register file, readable through an asynchronous read port.
- Sits at the far end of the TX line. Used for loopback in the lab setup and as the data sink for the transmitter core.

Parameters:
- NWORDS, 16, words per frame (must be 2**AW)
- AW, 4, word-address width
- DW, 4, bits per word (must be 4; BW = 2)

Ports:
- hit  in  1  clock; all state changes on rising edge
- clr  in  1  synchronous active-high reset
- RX  in  1  serial data, sampled on hit edge when EN=1
- EN  in  1  bit-valid strobe; one RX bit consumed per cycle with EN=1
- SYNC  in  1  frame start; cycle with SYNC=1 is word 0 bit 0 (if EN=1)
- NOM  out  4  address of word currently being received
- BIT  out  2  index of next bit expected within word
- LE  out  4  last completed word
- WE  out  1  one-cycle pulse, cycle after a word completes
- FRM  out  1  one-cycle pulse, cycle after word 15 completes
- BUSY  out  1  high in RECV state
- RD_A  in  4  read address
- RD_D  out  4  mem[RD_A], combinational
- ERR  out  1  sticky compare error (see Optional Feature)

Behaviour:
- Reset (clr=1 at edge, overrides everything):
  - state=IDLE; NOM=0, BIT=0, LE=0, WE=0, FRM=0, ERR=0, BUSY=0.
  - All 16 mem words = 4'h0; shift register = 0.
- States IDLE, RECV, DONE. BUSY = (state==RECV).
- IDLE/DONE:
  - EN ignored, no writes.
  - SYNC=1 -> RECV with NOM=0, BIT=0.
  - If EN=1 in the same cycle, RX is taken as word 0 bit 0 and BIT becomes 1.
- RECV, EN=1, BIT<3: shift[BIT] <= RX; BIT <= BIT+1.
- RECV, EN=1, BIT==3 (word complete):
  - word = {RX, shift[2:0]}; mem[NOM] <= word; LE <= word.
  - WE=1 next cycle; BIT <= 0.
  - If NOM<15: NOM <= NOM+1.
  - If NOM==15: FRM=1 next cycle, NOM <= 0 (wrap), state -> DONE.
- RECV, EN=0: hold all counters; no timeout. Gaps of any length are allowed between bits.
- SYNC=1 in RECV: abort the partial word, discard it, restart at NOM=0/BIT=0, same rule as in IDLE.
  - Words already written are kept.
  - No WE/FRM for the aborted word.
- SYNC on the same cycle as word 15 completing: SYNC wins, no write, no FRM.
- WE and FRM are registered pulses: exactly 1 cycle, never stretched.
  - Back-to-back words with EN held high: WE every 4th cycle.
- Latency: last bit sampled at edge N -> mem/LE updated at edge N, WE/FRM high during cycle after edge N.
- Read port:
  - RD_D = mem[RD_A], asynchronous.
  - A same-cycle write to RD_A shows the old value until the edge.
- Frame timing: 64 EN cycles from SYNC through frame end. Minimum frame is 64 clocks.

Optional Feature:
- Macro: CORE_RX_CMP_EN
- Defined:
  - Each completed word is compared against the package constant table REF_WORDS[NOM] (the same contents as the transmitter ROM).
  - On mismatch ERR <= 1 (sticky) at the write edge.
  - ERR cleared by clr, or by SYNC accepted in any state.
- Undefined: ERR tied to 0, no table logic.
- Port list identical in both builds.

Decomposition:
- Package core_rx_pkg:
  - NWORDS, AW, DW, BW.
  - State encoding: IDLE=2'd0, RECV=2'd1, DONE=2'd2.
  - REF_WORDS 16x4 constant table, shared with the transmitter ROM contents.
- One sub-module: rx_store_16x4.
  - Synchronous write (we, wa, wd), asynchronous read (ra, rd), synchronous clear on clr.
- Counter, shift register and FSM stay in core_rx.

Test Plan:
- clr for 2 cycles, then idle -> NOM=0, BIT=0, LE=0, WE=0, FRM=0, BUSY=0; RD_D=0 for every RD_A 0..15.
- SYNC+EN on cycle 0, then 63 EN cycles streaming words 0x0..0xF LSB-first -> WE pulses on cycles 4, 8, ..., 64; FRM=1 only on cycle 64; mem[i]=i; LE=4'hF; state DONE, BUSY=0.
- Word 0 = 4'hA sent with EN=0 gaps of 3 cycles between bits -> BIT steps 0..3 only on EN cycles; LE=4'hA; WE single-cycle.
- SYNC asserted after 2 bits of word 5 -> NOM=0, BIT=0 (or 1 if EN); no WE for the partial word; mem[0..4] retain prior values.
- clr asserted mid-frame at NOM=7, BIT=2 -> next cycle all outputs zero, mem cleared, state IDLE; a subsequent EN without SYNC causes no writes.
- CORE_RX_CMP_EN defined, frame with word 3 corrupted (bit 2 flipped) -> ERR rises at word 3's write edge, stays 1 through FRM; next SYNC clears ERR. Macro undefined -> ERR=0 throughout.

Source files
------------

// File: rtl/core_rx_pkg.sv
// Shared constants, FSM encoding and reference word table for the 16x4 serial receiver.
package core_rx_pkg;

  localparam int NWORDS = 16;
  localparam int AW     = 4;
  localparam int DW     = 4;
  localparam int BW     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } rx_state_t;

  // Same contents as the transmitter ROM: word i holds the value i.
  localparam logic [NWORDS-1:0][DW-1:0] REF_WORDS = 64'hFEDC_BA98_7654_3210;

  function automatic logic [DW-1:0] ref_word(input logic [AW-1:0] addr);
    return REF_WORDS[addr];
  endfunction

endpackage

// File: rtl/rx_store_16x4.sv
// 16x4 register file: synchronous write and clear, asynchronous read.
module rx_store_16x4
  import core_rx_pkg::*;
(
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd
);

  logic [DW-1:0] mem [NWORDS];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NWORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  // A write to ra in this cycle is only visible after the edge.
  assign rd = mem[ra];

endmodule

// File: rtl/core_rx.sv
// Serial receiver: deserialises a 64-bit frame (word 0 first, LSB first) into 16 x 4-bit words.
// Optional build macro CORE_RX_CMP_EN enables the sticky compare against REF_WORDS on ERR.
module core_rx
  import core_rx_pkg::*;
(
  input  logic          hit,
  input  logic          clr,
  input  logic          RX,
  input  logic          EN,
  input  logic          SYNC,
  output logic [AW-1:0] NOM,
  output logic [BW-1:0] BIT,
  output logic [DW-1:0] LE,
  output logic          WE,
  output logic          FRM,
  output logic          BUSY,
  input  logic [AW-1:0] RD_A,
  output logic [DW-1:0] RD_D,
  output logic          ERR
);

  rx_state_t     state;
  logic [DW-2:0] shift;
  logic          word_done;
  logic [DW-1:0] word;

  // SYNC takes priority, so a word completing alongside SYNC is never stored.
  assign word_done = (state == RECV) && EN && !SYNC && (BIT == BW'(DW - 1));
  assign word      = {RX, shift};
  assign BUSY      = (state == RECV);

  always_ff @(posedge hit) begin
    if (clr) begin
      state <= IDLE;
      NOM   <= '0;
      BIT   <= '0;
      LE    <= '0;
      WE    <= 1'b0;
      FRM   <= 1'b0;
      shift <= '0;
    end else begin
      WE  <= 1'b0;
      FRM <= 1'b0;
      if (SYNC) begin
        state <= RECV;
        NOM   <= '0;
        if (EN) begin
          shift[0] <= RX;
          BIT      <= BW'(1);
        end else begin
          BIT <= '0;
        end
      end else if ((state == RECV) && EN) begin
        if (word_done) begin
          LE  <= word;
          WE  <= 1'b1;
          BIT <= '0;
          if (NOM == AW'(NWORDS - 1)) begin
            FRM   <= 1'b1;
            NOM   <= '0;
            state <= DONE;
          end else begin
            NOM <= NOM + AW'(1);
          end
        end else begin
          shift[BIT] <= RX;
          BIT        <= BIT + BW'(1);
        end
      end
    end
  end

  rx_store_16x4 u_store (
    .clk (hit),
    .clr (clr),
    .we  (word_done),
    .wa  (NOM),
    .wd  (word),
    .ra  (RD_A),
    .rd  (RD_D)
  );

`ifdef CORE_RX_CMP_EN
  // Sticky mismatch flag; a new frame start clears it.
  always_ff @(posedge hit) begin
    if (clr) begin
      ERR <= 1'b0;
    end else if (SYNC) begin
      ERR <= 1'b0;
    end else if (word_done && (word != ref_word(NOM))) begin
      ERR <= 1'b1;
    end
  end
`else
  assign ERR = 1'b0;
`endif

endmodule
